// File: rtl/pdm_mic_ctrl.sv
// pdm_mic_ctrl: sequencing controller for one PDM mic channel and its sinc3 filter.
// Holds the filter through wake-up, discards settling words, then buffers output words.
module pdm_mic_ctrl #(
    parameter int WAKE_CYCLES  = 1024,
    parameter int SETTLE_WORDS = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        mclk1,
    input  logic        reset,
    input  logic        enable,
    output logic        filt_rst,
    input  logic [15:0] filt_data,
    input  logic        filt_en,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        overflow,
    output logic [1:0]  state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(WAKE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_WORDS + 1);

    localparam logic [WW-1:0] WAKE_LOAD   = WW'(WAKE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_WORDS - 1);
    localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAKE   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t        cur;
    logic [WW-1:0] wake_cnt;
    logic [SW-1:0] settle_cnt;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic push;
    logic pop;
    logic full;
    logic do_write;

    assign state    = cur;
    assign m_valid  = (count != '0);
    assign m_data   = mem[rd_ptr];
    assign full     = (count == FULL_CNT);
    assign pop      = m_valid && m_ready;
    assign push     = (cur == RUN) && filt_en && enable;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign do_write = push && (!full || pop);

    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            cur        <= IDLE;
            filt_rst   <= 1'b1;
            wake_cnt   <= '0;
            settle_cnt <= '0;
        end else if (!enable) begin
            cur        <= IDLE;
            filt_rst   <= 1'b1;
            wake_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            unique case (cur)
                IDLE: begin
                    cur      <= WAKE;
                    filt_rst <= 1'b1;
                    wake_cnt <= WAKE_LOAD;
                end
                WAKE: begin
                    if (wake_cnt == '0) begin
                        cur      <= SETTLE;
                        filt_rst <= 1'b0;
                    end else begin
                        wake_cnt <= wake_cnt - WW'(1);
                    end
                end
                SETTLE: begin
                    if (filt_en) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            cur        <= RUN;
                            settle_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                end
                RUN: begin
                    cur <= RUN;
                end
                default: begin
                    cur      <= IDLE;
                    filt_rst <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (!enable) begin
            // Flush only; overflow stays visible until the next start.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (cur == IDLE) begin
                overflow <= 1'b0;
            end else if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_write, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge mclk1 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write && enable) begin
            mem[wr_ptr] <= filt_data;
        end
    end

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// tb_pdm_mic_ctrl: directed + randomized bench for pdm_mic_ctrl.
// FIFO contents are predicted with a queue; sequencing from the stated cycle timing.
module tb_pdm_mic_ctrl;

    localparam int WAKE   = 8;
    localparam int SETTLE = 4;
    localparam int DEPTH  = 4;

    logic        mclk1 = 1'b0;
    logic        reset;
    logic        enable;
    logic        filt_rst;
    logic [15:0] filt_data;
    logic        filt_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        overflow;
    logic [1:0]  state;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [15:0] q[$];
    logic        ovf_m = 1'b0;
    bit          run_m = 1'b0;

    always #5 mclk1 = ~mclk1;

    pdm_mic_ctrl #(
        .WAKE_CYCLES (WAKE),
        .SETTLE_WORDS(SETTLE),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .mclk1    (mclk1),
        .reset    (reset),
        .enable   (enable),
        .filt_rst (filt_rst),
        .filt_data(filt_data),
        .filt_en  (filt_en),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .overflow (overflow),
        .state    (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the queue model consumes the inputs that were sampled on it.
    task automatic cycle();
        bit pop;
        bit push;
        @(posedge mclk1);
        pop  = (q.size() > 0) && m_ready;
        push = run_m && filt_en && enable;
        if (!enable) begin
            q.delete();
            run_m = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() == DEPTH) ovf_m = 1'b1;
                else q.push_back(filt_data);
            end
        end
        #1;
    endtask

    task automatic check_fifo(input string tag);
        chk({tag, "_valid"}, {31'd0, m_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) chk({tag, "_data"}, {16'd0, m_data}, {16'd0, q[0]});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ovf_m});
    endtask

    task automatic pulse(input logic [15:0] d);
        filt_data = d;
        filt_en   = 1'b1;
        cycle();
        filt_en   = 1'b0;
    endtask

    // Raise enable, walk WAKE, feed SETTLE discard words base+1..base+SETTLE.
    task automatic start(input logic [15:0] base);
        enable = 1'b1;
        ovf_m  = 1'b0;
        cycle();
        chk("start_ovf_clr", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < WAKE; i++) begin
            chk("wake_state", {30'd0, state}, 32'd1);
            chk("wake_frst", {31'd0, filt_rst}, 32'd1);
            filt_en   = (i == 3) || (i == WAKE - 1);
            filt_data = 16'hDEAD;
            cycle();
            filt_en   = 1'b0;
        end
        chk("settle_state", {30'd0, state}, 32'd2);
        chk("settle_frst", {31'd0, filt_rst}, 32'd0);
        for (int w = 1; w <= SETTLE; w++) begin
            pulse(base + 16'(w));
            chk("settle_novalid", {31'd0, m_valid}, 32'd0);
            chk("settle_progress", {30'd0, state}, (w < SETTLE) ? 32'd2 : 32'd3);
            for (int k = 0; k < 9; k++) cycle();
        end
        run_m = 1'b1;
    endtask

    initial begin
        int got;
        reset     = 1'b1;
        enable    = 1'b0;
        filt_en   = 1'b0;
        filt_data = '0;
        m_ready   = 1'b0;
        #1;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_frst", {31'd0, filt_rst}, 32'd1);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", {16'd0, m_data}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge mclk1);
        #3;
        reset = 1'b0;
        cycle();
        chk("idle_state", {30'd0, state}, 32'd0);

        // Start-up: words 1..4 discarded, word 5 is first out.
        start(16'h0000);
        pulse(16'h0005);
        chk("first_word", {16'd0, m_data}, 32'h0005);
        check_fifo("first");
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        check_fifo("drain5");

        // Overflow with back-to-back pulses.
        for (int i = 0; i < 6; i++) begin
            pulse(16'hA000 + 16'(i));
            check_fifo("ovf_fill");
            if (i == 3) chk("ovf_after4", {31'd0, overflow}, 32'd0);
            if (i == 4) chk("ovf_after5", {31'd0, overflow}, 32'd1);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain", {16'd0, m_data}, 32'hA000 + 32'(i));
            cycle();
        end
        chk("ovf_empty", {31'd0, m_valid}, 32'd0);
        m_ready = 1'b0;

        // Disable with 2 queued; filt_en on the disabling edge is dropped.
        pulse(16'hB0B0);
        pulse(16'hB0B1);
        check_fifo("dis_pre");
        enable    = 1'b0;
        filt_en   = 1'b1;
        filt_data = 16'hBAD0;
        cycle();
        filt_en   = 1'b0;
        chk("dis_valid", {31'd0, m_valid}, 32'd0);
        chk("dis_frst", {31'd0, filt_rst}, 32'd1);
        chk("dis_state", {30'd0, state}, 32'd0);
        chk("dis_ovf_hold", {31'd0, overflow}, 32'd1);
        start(16'h0100);
        chk("reen_empty", {31'd0, m_valid}, 32'd0);

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) pulse(16'hB000 + 16'(i));
        check_fifo("full");
        m_ready = 1'b1;
        pulse(16'hB004);
        m_ready = 1'b0;
        check_fifo("pp_full");
        chk("pp_ovf", {31'd0, overflow}, 32'd0);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("pp_order", {16'd0, m_data}, 32'hB000 + 32'(i));
            cycle();
        end
        chk("pp_empty", {31'd0, m_valid}, 32'd0);

        // Wrap-around streaming, one word per 5 cycles.
        got = 0;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 5; k++) begin
                if (m_valid && m_ready) begin
                    chk("stream", {16'd0, m_data}, 32'hC000 + 32'(got));
                    got++;
                end
                filt_en   = (k == 0);
                filt_data = 16'hC000 + 16'(i);
                cycle();
                filt_en   = 1'b0;
                check_fifo("stream_q");
            end
        end
        chk("stream_cnt", got, 32'd20);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 300; n++) begin
            filt_en   = ($urandom_range(0, 2) == 0);
            m_ready   = ($urandom_range(0, 3) != 0);
            filt_data = 16'($urandom);
            cycle();
            check_fifo("rand");
        end
        filt_en = 1'b0;

        // Reset mid-RUN with 3 words queued and overflow set.
        m_ready = 1'b1;
        while (q.size() > 0) begin
            cycle();
        end
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse(16'hD000 + 16'(i));
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        chk("pre_rst_words", q.size(), 32'd3);
        check_fifo("pre_rst");
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_state", {30'd0, state}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        chk("mid_rst_frst", {31'd0, filt_rst}, 32'd1);
        q.delete();
        run_m = 1'b0;
        ovf_m = 1'b0;
        enable = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
